symbol_packer: RTL and testbench
================================

SYMBOL_PACKER -- requirements
Module: symbol_packer

Interface
REQ-001 Parameter CNT_W, default 16, width of the statistics counters (used only under REQ-024).
REQ-002 iclk  input  1  single clock; all state changes on the rising edge.
REQ-003 iresetn  input  1  asynchronous, active-low reset.
REQ-004 i_mod  input  2  modulation select: 0=BPSK, 1=QPSK, 2=PSK8; 3 treated as BPSK.
REQ-005 i_valid  input  1  input bit valid.
REQ-006 i_bit  input  1  serial data bit.
REQ-007 i_last  input  1  last bit of frame, qualified by i_valid.
REQ-008 o_ready  output  1  packer accepts a bit this cycle.
REQ-009 o_valid  output  1  output symbol valid.
REQ-010 o_sym  output  3  symbol index, right-justified; unused upper bits zero.
REQ-011 o_last  output  1  last symbol of frame, qualified by o_valid.
REQ-012 i_ready  input  1  downstream accepts symbol.

Function
REQ-013 A bit transfers when i_valid && o_ready; a symbol transfers when o_valid && i_ready.
REQ-014 o_ready = !o_valid || i_ready (combinational); no other stall source.
REQ-015 Symbol size: BPSK 1, QPSK 2, PSK8 3 bits, taken from the shared package function.
REQ-016 FSM states IDLE (no partial bits held) and FILL (1..size-1 bits held).
REQ-017 IDLE: on a bit transfer, i_mod is latched as the frame modulation and the bit is stored; the next state is FILL if size>1 and the bit is not last, otherwise a symbol is emitted and the state stays IDLE.
REQ-018 i_mod is sampled only at the first bit of a frame; changes mid-frame are ignored until the bit after an i_last transfer.
REQ-019 Bits are packed MSB-first: the first bit of a symbol is o_sym[size-1]; the symbol is emitted when the bit count reaches size.
REQ-020 An i_last transfer with a partial symbol emits it immediately, zero-padding the missing LSBs, with o_last=1; state returns to IDLE.
REQ-021 Latency: a symbol appears on o_valid/o_sym/o_last exactly one cycle after its final bit transfer; full throughput of one bit per cycle with i_ready held high.
REQ-022 o_valid, o_sym and o_last hold stable while o_valid && !i_ready.

Reset
REQ-023 With iresetn low: state IDLE, bit counter 0, shift register 0, latched modulation BPSK, o_valid 0, o_sym 0, o_last 0; a partial symbol in progress is discarded, and the first bit after release starts a new frame.

Configuration
REQ-024 Macro SYMBOL_PACKER_STATS_EN: when defined, adds outputs o_sym_cnt (CNT_W, symbols transferred out) and o_pad_cnt (CNT_W, padded symbols transferred out), both wrapping at 2^CNT_W and reset to 0; when not defined, these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-025 t_modulation, t_modulation_settings and get_modulation_settings stay in the shared modem package; the package additionally gains the constant MAX_SYMBOL_SIZE = 3 and a function mapping the 2-bit i_mod code to t_modulation (3 -> BPSK).
REQ-026 A single module, no sub-modules; the shift register is MAX_SYMBOL_SIZE bits wide.

Verification
REQ-027 QPSK, bits 1,0,1,1,0,0 with i_ready=1 -> o_sym 2,3,0 on consecutive cycles, the first one cycle after the 2nd bit; o_last only on 0 if i_last is on the 6th bit.
REQ-028 PSK8, bits 1,1 with i_last on the 2nd -> one symbol o_sym=6 with o_last=1; with STATS_EN, o_pad_cnt=1.
REQ-029 BPSK then i_mod=3 -> each bit is emitted as o_sym=bit with o_sym[2:1]=0, one per cycle.
REQ-030 QPSK stream with i_ready held low for 3 cycles -> o_ready low, o_sym stable, no bits lost or duplicated after release.
REQ-031 i_mod toggles QPSK->PSK8 mid-frame -> packing stays 2-bit until after the i_last transfer, then 3-bit.
REQ-032 iresetn pulsed low after 2 PSK8 bits -> o_valid=0 at once; the next 3 bits form a fresh symbol with no leftover bits.

Source files
------------

// File: rtl/symbol_packer_pkg.sv
// Shared modem package: modulation types, per-modulation settings and mode decode.
package symbol_packer_pkg;

  localparam int unsigned MAX_SYMBOL_SIZE = 3;
  localparam int unsigned BIT_CNT_W       = 2;
  localparam int unsigned MOD_W           = 2;

  typedef enum logic [MOD_W-1:0] {
    MOD_BPSK = 2'd0,
    MOD_QPSK = 2'd1,
    MOD_PSK8 = 2'd2
  } t_modulation;

  typedef struct packed {
    logic [BIT_CNT_W-1:0] bits_per_symbol;
  } t_modulation_settings;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } t_packer_state;

  // Bits carried by one symbol of the given modulation.
  function automatic t_modulation_settings get_modulation_settings(input t_modulation mod);
    t_modulation_settings s;
    s.bits_per_symbol = BIT_CNT_W'(1);
    case (mod)
      MOD_QPSK: s.bits_per_symbol = BIT_CNT_W'(2);
      MOD_PSK8: s.bits_per_symbol = BIT_CNT_W'(3);
      default:  s.bits_per_symbol = BIT_CNT_W'(1);
    endcase
    return s;
  endfunction

  // Map the 2-bit select code onto a modulation; the reserved code falls back to BPSK.
  function automatic t_modulation decode_modulation(input logic [MOD_W-1:0] code);
    t_modulation m;
    case (code)
      2'd1:    m = MOD_QPSK;
      2'd2:    m = MOD_PSK8;
      default: m = MOD_BPSK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/symbol_packer.sv
// Serial bit to symbol packer (BPSK/QPSK/PSK8), MSB-first, one symbol of output buffering.
// Optional statistics counters are enabled by defining SYMBOL_PACKER_STATS_EN.
module symbol_packer
  import symbol_packer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                       iclk,
  input  logic                       iresetn,
  input  logic [MOD_W-1:0]           i_mod,
  input  logic                       i_valid,
  input  logic                       i_bit,
  input  logic                       i_last,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [MAX_SYMBOL_SIZE-1:0] o_sym,
  output logic                       o_last,
  input  logic                       i_ready
`ifdef SYMBOL_PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]           o_sym_cnt,
  output logic [CNT_W-1:0]           o_pad_cnt
`endif
);

  t_packer_state              state;
  t_packer_state              state_next;
  t_modulation                mod_q;
  logic                       frame_open;
  logic [BIT_CNT_W-1:0]       cnt_q;
  logic [MAX_SYMBOL_SIZE-1:0] sh_q;

  logic                       bit_xfer;
  logic                       sym_xfer;
  t_modulation                frame_mod;
  t_modulation_settings       settings;
  logic [BIT_CNT_W-1:0]       size;
  logic [BIT_CNT_W-1:0]       base_cnt;
  logic [BIT_CNT_W-1:0]       fill_cnt;
  logic [BIT_CNT_W-1:0]       pos;
  logic [MAX_SYMBOL_SIZE-1:0] base_sh;
  logic [MAX_SYMBOL_SIZE-1:0] packed_sh;
  logic                       emit;

  assign o_ready  = !o_valid || i_ready;
  assign bit_xfer = i_valid && o_ready;
  assign sym_xfer = o_valid && i_ready;

  // State register.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state: a completed or terminated symbol always returns to IDLE.
  always_comb begin
    state_next = state;
    if (bit_xfer) state_next = emit ? ST_IDLE : ST_FILL;
  end

  // Datapath decode: modulation of the frame, bit placement and emit decision.
  always_comb begin
    frame_mod = mod_q;
    settings  = get_modulation_settings(MOD_BPSK);
    size      = BIT_CNT_W'(1);
    base_cnt  = cnt_q;
    base_sh   = sh_q;
    fill_cnt  = BIT_CNT_W'(1);
    pos       = '0;
    packed_sh = '0;
    emit      = 1'b0;

    // i_mod is only honoured on the first bit of a frame.
    if (state == ST_IDLE && !frame_open) frame_mod = decode_modulation(i_mod);
    settings = get_modulation_settings(frame_mod);
    size     = settings.bits_per_symbol;

    if (state == ST_IDLE) begin
      base_cnt = '0;
      base_sh  = '0;
    end

    fill_cnt  = BIT_CNT_W'(base_cnt + BIT_CNT_W'(1));
    pos       = BIT_CNT_W'(size - fill_cnt);
    packed_sh = base_sh | (MAX_SYMBOL_SIZE'(i_bit) << pos);
    emit      = bit_xfer && ((fill_cnt == size) || i_last);
  end

  // Partial-symbol storage and frame tracking.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      mod_q      <= MOD_BPSK;
      frame_open <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
    end else if (bit_xfer) begin
      mod_q      <= frame_mod;
      frame_open <= !i_last;
      cnt_q      <= emit ? '0 : fill_cnt;
      sh_q       <= emit ? '0 : packed_sh;
    end
  end

  // Output symbol register; holds while downstream stalls.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      o_valid <= 1'b0;
      o_sym   <= '0;
      o_last  <= 1'b0;
    end else if (emit) begin
      o_valid <= 1'b1;
      o_sym   <= packed_sh;
      o_last  <= i_last;
    end else if (sym_xfer) begin
      o_valid <= 1'b0;
    end
  end

`ifdef SYMBOL_PACKER_STATS_EN
  logic pad_q;

  // Remember whether the symbol in the output register was zero-padded.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn)  pad_q <= 1'b0;
    else if (emit) pad_q <= (fill_cnt != size);
  end

  // Count symbols (and padded symbols) accepted downstream.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      o_sym_cnt <= '0;
      o_pad_cnt <= '0;
    end else if (sym_xfer) begin
      o_sym_cnt <= CNT_W'(o_sym_cnt + CNT_W'(1));
      if (pad_q) o_pad_cnt <= CNT_W'(o_pad_cnt + CNT_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_symbol_packer.sv
// Self-checking bench for symbol_packer: directed scenarios plus randomized traffic
// against a frame-level reference model.
module tb_symbol_packer;

  logic       clk = 1'b0;
  logic       iresetn;
  logic [1:0] i_mod;
  logic       i_valid;
  logic       i_bit;
  logic       i_last;
  logic       o_ready;
  logic       o_valid;
  logic [2:0] o_sym;
  logic       o_last;
  logic       i_ready;
`ifdef SYMBOL_PACKER_STATS_EN
  logic [15:0] o_sym_cnt;
  logic [15:0] o_pad_cnt;
`endif

  symbol_packer #(.CNT_W(16)) dut (
    .iclk    (clk),
    .iresetn (iresetn),
    .i_mod   (i_mod),
    .i_valid (i_valid),
    .i_bit   (i_bit),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_sym   (o_sym),
    .o_last  (o_last),
    .i_ready (i_ready)
`ifdef SYMBOL_PACKER_STATS_EN
    ,
    .o_sym_cnt (o_sym_cnt),
    .o_pad_cnt (o_pad_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sym;
    logic       last;
    logic       pad;
  } exp_t;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model state: frame-level view of the bit stream.
  exp_t        exp_q[$];
  logic [3:0]  out_log[$];
  bit          m_frame_start = 1'b1;
  int          m_size  = 1;
  int          m_nbits = 0;
  int          m_acc   = 0;
  int unsigned m_sym_cnt = 0;
  int unsigned m_pad_cnt = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sym_size(input logic [1:0] m);
    case (m)
      2'd1:    return 2;
      2'd2:    return 3;
      default: return 1;
    endcase
  endfunction

  // Feed one accepted bit into the model; reports a finished symbol if any.
  task automatic model_bit(input logic b, input logic l, input logic [1:0] m,
                           output exp_t mk, output logic made);
    made = 1'b0;
    mk   = '0;
    if (m_frame_start) m_size = sym_size(m);
    m_frame_start = l;
    m_acc = m_acc + (int'(b) << (m_size - 1 - m_nbits));
    m_nbits++;
    if (m_nbits == m_size || l) begin
      mk.sym  = 3'(m_acc);
      mk.last = l;
      mk.pad  = (m_nbits != m_size);
      exp_q.push_back(mk);
      made    = 1'b1;
      m_nbits = 0;
      m_acc   = 0;
    end
  endtask

  task automatic check_stats();
`ifdef SYMBOL_PACKER_STATS_EN
    check("sym_cnt", o_sym_cnt, m_sym_cnt & 32'hFFFF);
    check("pad_cnt", o_pad_cnt, m_pad_cnt & 32'hFFFF);
`endif
  endtask

  // One clock cycle of stimulus with all per-cycle checks.
  task automatic step(input logic v, input logic b, input logic l,
                      input logic [1:0] m, input logic r);
    logic       bx, sx, hold, made;
    logic [2:0] psym;
    logic       plast;
    exp_t       e, mk;
    @(negedge clk);
    i_valid = v; i_bit = b; i_last = l; i_mod = m; i_ready = r;
    #1;
    check("o_ready", o_ready, (!o_valid || r));
    bx    = v && o_ready;
    sx    = o_valid && r;
    hold  = o_valid && !r;
    psym  = o_sym;
    plast = o_last;
    made  = 1'b0;
    if (sx) begin
      out_log.push_back({o_last, o_sym});
      if (exp_q.size() == 0) begin
        check("spurious_sym", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sym", o_sym, e.sym);
        check("last", o_last, e.last);
        m_sym_cnt++;
        if (e.pad) m_pad_cnt++;
      end
    end
    if (bx) model_bit(b, l, m, mk, made);
    @(posedge clk);
    #1;
    if (made) begin
      check("lat_valid", o_valid, 1);
      check("lat_sym", o_sym, mk.sym);
      check("lat_last", o_last, mk.last);
    end else if (hold) begin
      check("hold_valid", o_valid, 1);
      check("hold_sym", o_sym, psym);
      check("hold_last", o_last, plast);
    end else begin
      check("valid_drop", o_valid, 0);
    end
    check_stats();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0; i_last = 1'b0; i_bit = 1'b0; i_ready = 1'b1;
    iresetn = 1'b0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_sym", o_sym, 0);
    check("rst_last", o_last, 0);
    exp_q.delete();
    m_frame_start = 1'b1;
    m_nbits = 0;
    m_acc   = 0;
    m_sym_cnt = 0;
    m_pad_cnt = 0;
    check_stats();
    @(negedge clk);
    iresetn = 1'b1;
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic expect_log(input string tag, input logic [3:0] exp_a[6], input int n);
    check({tag, "_count"}, out_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < out_log.size()) check(tag, out_log[i], exp_a[i]);
    out_log.delete();
  endtask

  initial begin
    iresetn = 1'b0;
    i_mod = 2'd0; i_valid = 1'b0; i_bit = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    out_log.delete();

    // QPSK 1,0,1,1,0,0 with last on the sixth bit -> 2, 3, 0(last)
    step(1, 1, 0, 2'd1, 1); step(1, 0, 0, 2'd1, 1); step(1, 1, 0, 2'd1, 1);
    step(1, 1, 0, 2'd1, 1); step(1, 0, 0, 2'd1, 1); step(1, 0, 1, 2'd1, 1);
    drain();
    expect_log("qpsk_seq", '{4'h2, 4'h3, 4'h8, 4'h0, 4'h0, 4'h0}, 3);

    // PSK8 truncated frame 1,1 -> 6(last), padded
    do_reset();
    out_log.delete();
    step(1, 1, 0, 2'd2, 1); step(1, 1, 1, 2'd2, 1);
    drain();
    expect_log("psk8_pad", '{4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 1);
`ifdef SYMBOL_PACKER_STATS_EN
    check("pad_cnt_dir", o_pad_cnt, 1);
`endif

    // BPSK frame then reserved code 3 -> one symbol per bit
    step(1, 1, 0, 2'd0, 1); step(1, 0, 1, 2'd0, 1);
    step(1, 1, 0, 2'd3, 1); step(1, 1, 0, 2'd3, 1); step(1, 0, 1, 2'd3, 1);
    drain();
    expect_log("bpsk_seq", '{4'h1, 4'h8, 4'h1, 4'h1, 4'h8, 4'h0}, 5);

    // QPSK with downstream stalled for three cycles
    step(1, 1, 0, 2'd1, 1); step(1, 1, 0, 2'd1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 2'd1, 0);
      check("stall_ready", o_ready, 0);
    end
    step(1, 0, 0, 2'd1, 1); step(1, 1, 1, 2'd1, 1);
    drain();
    expect_log("stall_seq", '{4'h3, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0}, 2);

    // Mode change mid-frame takes effect only after the last bit
    step(1, 1, 0, 2'd1, 1); step(1, 0, 0, 2'd1, 1);
    step(1, 1, 0, 2'd2, 1); step(1, 1, 1, 2'd2, 1);
    step(1, 1, 0, 2'd2, 1); step(1, 0, 0, 2'd2, 1); step(1, 1, 1, 2'd2, 1);
    drain();
    expect_log("mod_switch", '{4'h2, 4'hB, 4'hD, 4'h0, 4'h0, 4'h0}, 3);

    // Reset after two PSK8 bits discards the partial symbol
    step(1, 1, 0, 2'd2, 1); step(1, 1, 0, 2'd2, 1);
    do_reset();
    out_log.delete();
    step(1, 0, 0, 2'd2, 1); step(1, 0, 0, 2'd2, 1); step(1, 1, 1, 2'd2, 1);
    drain();
    expect_log("post_reset", '{4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 7));
    end
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
